filter_output_arbiter: RTL and testbench

Round-robin arbiter that drains the pass buffers of `NUM_FILTER` parallel `filter_logic` instances and forwards one (home particle ID, neighbour position) pair per cycle to the force evaluation pipeline. It issues the one-cycle buffer read enables that those filters expect. A read of an empty buffer is the filters' release mechanism, so such reads are required, and the arbiter discards their invalid data. It sits directly downstream of the filter array and upstream of the force pipeline input register.

---
 rtl/filter_output_arbiter.sv | 97 +++++++++
 tb/tb_filter_output_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_output_arbiter.sv
// Round-robin drain of the filter pass buffers into the force pipeline.
// Grant at T, capture filter data at T+1, registered pair out at T+2.
module filter_output_arbiter #(
    parameter int NUM_FILTER           = 8,
    parameter int PARTICLE_ID_WIDTH    = 16,
    parameter int POS_PKT_STRUCT_WIDTH = 32,
    parameter int FID_WIDTH            = $clog2(NUM_FILTER)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_FILTER-1:0]                      i_filter_request,
    input  logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0]    i_buffer_rd_data,
    input  logic [NUM_FILTER-1:0]                      i_buffer_rd_data_valid,
    input  logic [NUM_FILTER*POS_PKT_STRUCT_WIDTH-1:0] i_nb_reg,
    input  logic                                       i_frc_almost_full,
    output logic [NUM_FILTER-1:0]                      o_buffer_rd_en,
    output logic                                       o_pair_valid,
    output logic [PARTICLE_ID_WIDTH-1:0]               o_home_parid,
    output logic [POS_PKT_STRUCT_WIDTH-1:0]            o_nb_pos,
    output logic [FID_WIDTH-1:0]                       o_filter_id
);

    localparam int PW = PARTICLE_ID_WIDTH;
    localparam int NW = POS_PKT_STRUCT_WIDTH;

    logic [FID_WIDTH-1:0]  rr_ptr;
    logic [NUM_FILTER-1:0] mask;
    logic                  cap_vld;
    logic [FID_WIDTH-1:0]  cap_idx;

    logic [NUM_FILTER-1:0] elig;
    logic [NUM_FILTER-1:0] grant;
    logic                  found;
    logic [FID_WIDTH-1:0]  win;
    logic [FID_WIDTH-1:0]  next_ptr;
    logic [FID_WIDTH:0]    sum;

    // The previous grant is masked: the filter's request lags its read.
    always_comb begin
        elig  = i_filter_request & ~mask
              & {NUM_FILTER{~i_frc_almost_full}};
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < NUM_FILTER; i++) begin
            sum = {1'b0, rr_ptr} + (FID_WIDTH+1)'(i);
            if (sum >= (FID_WIDTH+1)'(NUM_FILTER)) begin
                sum = sum - (FID_WIDTH+1)'(NUM_FILTER);
            end
            if (!found && elig[sum]) begin
                found = 1'b1;
                win   = sum[FID_WIDTH-1:0];
            end
        end
        grant = '0;
        if (found && !rst) begin
            grant = NUM_FILTER'(1) << win;
        end
        if (win == FID_WIDTH'(NUM_FILTER - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = win + FID_WIDTH'(1);
        end
    end

    assign o_buffer_rd_en = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            mask         <= '0;
            cap_vld      <= 1'b0;
            cap_idx      <= '0;
            o_pair_valid <= 1'b0;
            o_home_parid <= '0;
            o_nb_pos     <= '0;
            o_filter_id  <= '0;
        end else begin
            mask    <= grant;
            cap_vld <= found;
            cap_idx <= win;
            if (found) begin
                rr_ptr <= next_ptr;
            end
            // Invalid data is a release read of an empty buffer: drop it.
            if (cap_vld && i_buffer_rd_data_valid[cap_idx]) begin
                o_pair_valid <= 1'b1;
                o_home_parid <= i_buffer_rd_data[int'(cap_idx)*PW +: PW];
                o_nb_pos     <= i_nb_reg[int'(cap_idx)*NW +: NW];
                o_filter_id  <= cap_idx;
            end else begin
                o_pair_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_filter_output_arbiter.sv
// Bench for filter_output_arbiter: behavioural filters feed the DUT,
// a monitor checks grants and pairs against queued expectations.
module tb_filter_output_arbiter;

    localparam int NF = 8;
    localparam int PW = 16;
    localparam int NW = 32;
    localparam int FW = 3;

    typedef struct packed {
        logic [PW-1:0] id;
        logic [NW-1:0] nb;
        logic [FW-1:0] f;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic af  = 1'b0;
    logic [NF-1:0]    req;
    logic [NF-1:0]    rdv = '0;
    logic [NF-1:0]    rd_en;
    logic [NF*PW-1:0] rdd = '0;
    logic [NF*NW-1:0] nbr = '0;
    logic             pv;
    logic [PW-1:0]    hp;
    logic [NW-1:0]    np;
    logic [FW-1:0]    fid;

    always #5 clk = ~clk;

    filter_output_arbiter #(
        .NUM_FILTER(NF), .PARTICLE_ID_WIDTH(PW),
        .POS_PKT_STRUCT_WIDTH(NW), .FID_WIDTH(FW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_filter_request(req),
        .i_buffer_rd_data(rdd),
        .i_buffer_rd_data_valid(rdv),
        .i_nb_reg(nbr),
        .i_frc_almost_full(af),
        .o_buffer_rd_en(rd_en),
        .o_pair_valid(pv),
        .o_home_parid(hp),
        .o_nb_pos(np),
        .o_filter_id(fid)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int exp_g[$];
    pair_t exp_p[$];

    function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endfunction

    function automatic logic [NW-1:0] nbf(int k, logic [PW-1:0] id);
        return {8'(k), 8'hA5, id};
    endfunction

    function automatic int idx_of(logic [NF-1:0] v);
        int r = -1;
        for (int i = 0; i < NF; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Behavioural filters: request until a read finds the buffer empty.
    logic [NF-1:0] active = '0;
    logic [NF-1:0] go = '0;
    int            ptr[NF];
    int            cfg_n[NF];
    logic [PW-1:0] cfg_ids[NF][4];

    assign req = active;

    always @(posedge clk) begin
        for (int k = 0; k < NF; k++) begin
            if (rst) begin
                active[k] <= 1'b0;
                rdv[k]    <= 1'b0;
            end else begin
                rdv[k] <= 1'b0;
                if (go[k]) begin
                    active[k] <= 1'b1;
                    ptr[k]    <= 0;
                end else if (rd_en[k]) begin
                    if (ptr[k] < cfg_n[k]) begin
                        rdd[k*PW +: PW] <= cfg_ids[k][ptr[k]];
                        nbr[k*NW +: NW] <= nbf(k, cfg_ids[k][ptr[k]]);
                        rdv[k]          <= 1'b1;
                        ptr[k]          <= ptr[k] + 1;
                    end else begin
                        active[k]       <= 1'b0;
                        rdd[k*PW +: PW] <= 16'hBAD0;
                    end
                end
            end
        end
    end

    logic [NF-1:0] prev_rd = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_rd <= '0;
        end else begin
            chk("rd_en_onehot", 64'($countones(rd_en) <= 1), 64'd1);
            if (af) chk("rd_en_while_stall", 64'(rd_en), 64'd0);
            chk("rd_en_back_to_back", 64'(rd_en & prev_rd), 64'd0);
            if (rd_en != '0) begin
                if (exp_g.size() == 0) begin
                    chk("grant_unexpected", 64'(rd_en), 64'd0);
                end else begin
                    chk("grant_index", 64'(idx_of(rd_en)),
                        64'(exp_g.pop_front()));
                end
            end
            if (pv) begin
                if (exp_p.size() == 0) begin
                    chk("pair_unexpected", 64'(pv), 64'd0);
                end else begin
                    chk("pair", 64'({hp, np, fid}), 64'(exp_p.pop_front()));
                end
            end
            prev_rd <= rd_en;
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        af  = 1'b0;
        go  = '0;
        for (int k = 0; k < NF; k++) cfg_n[k] = 0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic activate(logic [NF-1:0] m);
        go = m;
        cyc(1);
        go = '0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((active != '0 || pv) && t < 300) begin
            cyc(1);
            t++;
        end
        chk("idle_timeout", 64'(t < 300), 64'd1);
        cyc(4);
        chk("grants_drained", 64'(exp_g.size()), 64'd0);
        chk("pairs_drained", 64'(exp_p.size()), 64'd0);
    endtask

    task automatic push_pair(int k, logic [PW-1:0] id);
        exp_p.push_back('{id: id, nb: nbf(k, id), f: FW'(k)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("reset_rd_en", 64'(rd_en), 64'd0);
        chk("reset_pair_valid", 64'(pv), 64'd0);
        chk("reset_home_parid", 64'(hp), 64'd0);
        chk("reset_nb_pos", 64'(np), 64'd0);
        chk("reset_filter_id", 64'(fid), 64'd0);

        // Single filter: alternate-cycle grants, 4th read is a release.
        cfg_n[2] = 3;
        cfg_ids[2][0] = 16'd5;
        cfg_ids[2][1] = 16'd9;
        cfg_ids[2][2] = 16'd12;
        repeat (4) exp_g.push_back(2);
        push_pair(2, 16'd5);
        push_pair(2, 16'd9);
        push_pair(2, 16'd12);
        activate(8'h04);
        wait_idle();
        chk("hold_home_parid", 64'(hp), 64'd12);
        chk("hold_filter_id", 64'(fid), 64'd2);

        // Round robin over all eight filters, two IDs each.
        do_reset();
        for (int k = 0; k < NF; k++) begin
            cfg_n[k] = 2;
            cfg_ids[k][0] = 16'(100 + 10 * k);
            cfg_ids[k][1] = 16'(101 + 10 * k);
        end
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < NF; k++) exp_g.push_back(k);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NF; k++) push_pair(k, 16'(100 + 10 * k + r));
        activate(8'hFF);
        wait_idle();

        // Wrap: park the pointer at 6 with a release read of filter 5.
        do_reset();
        exp_g.push_back(5);
        activate(8'h20);
        wait_idle();
        cfg_n[1] = 1;
        cfg_ids[1][0] = 16'd77;
        cfg_n[6] = 1;
        cfg_ids[6][0] = 16'd66;
        exp_g.push_back(6);
        exp_g.push_back(1);
        exp_g.push_back(6);
        exp_g.push_back(1);
        push_pair(6, 16'd66);
        push_pair(1, 16'd77);
        activate(8'h42);
        wait_idle();
        for (int k = 0; k < NF; k++) cfg_n[k] = 0;
        for (int k = 2; k < NF + 2; k++) exp_g.push_back(k % NF);
        activate(8'hFF);
        wait_idle();

        // Stall right after a grant to filter 3.
        do_reset();
        cfg_n[3] = 1;
        cfg_ids[3][0] = 16'd33;
        cfg_n[5] = 1;
        cfg_ids[5][0] = 16'd55;
        exp_g.push_back(3);
        exp_g.push_back(5);
        exp_g.push_back(3);
        exp_g.push_back(5);
        push_pair(3, 16'd33);
        push_pair(5, 16'd55);
        activate(8'h28);
        cyc(1);
        af = 1'b1;
        cyc(1);
        chk("stall_pair_valid", 64'(pv), 64'd1);
        chk("stall_pair_fid", 64'(fid), 64'd3);
        cyc(4);
        af = 1'b0;
        wait_idle();

        // Reset the cycle after a grant: the in-flight capture is lost.
        do_reset();
        cfg_n[4] = 1;
        cfg_ids[4][0] = 16'd44;
        cfg_n[6] = 1;
        cfg_ids[6][0] = 16'd66;
        exp_g.push_back(4);
        activate(8'h50);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_pair_valid", 64'(pv), 64'd0);
        chk("midrst_home_parid", 64'(hp), 64'd0);
        chk("midrst_nb_pos", 64'(np), 64'd0);
        chk("midrst_filter_id", 64'(fid), 64'd0);
        chk("midrst_rd_en", 64'(rd_en), 64'd0);
        cyc(3);
        chk("midrst_grants_drained", 64'(exp_g.size()), 64'd0);
        exp_g.push_back(4);
        exp_g.push_back(6);
        exp_g.push_back(4);
        exp_g.push_back(6);
        push_pair(4, 16'd44);
        push_pair(6, 16'd66);
        activate(8'h50);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
